// File: rtl/stream_acc_pkg.sv
// Shared types and constants for the stream accumulator and its carry-lookahead adder.
package stream_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Bits resolved by one lookahead group inside the adder.
    localparam int unsigned CLA_BLK = 4;

endpackage

// File: rtl/stream_accumulator_cla.sv
// Carry-lookahead adder made of 4-bit lookahead groups; the group carry-out feeds the next group.
module cla
    import stream_acc_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] s,
    output logic             cout
);

    localparam int unsigned NBLK = width / CLA_BLK;

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;
    logic       c;

    always_comb begin
        s  = '0;
        g  = '0;
        p  = '0;
        cc = '0;
        c  = cin;
        for (int unsigned blk = 0; blk < NBLK; blk++) begin
            g = a[CLA_BLK*blk +: CLA_BLK] & b[CLA_BLK*blk +: CLA_BLK];
            p = a[CLA_BLK*blk +: CLA_BLK] ^ b[CLA_BLK*blk +: CLA_BLK];
            // All four group carries come straight from g/p and the group carry-in.
            cc[0] = c;
            cc[1] = g[0] | (p[0] & c);
            cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
            cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c);
            cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c);
            s[CLA_BLK*blk +: CLA_BLK] = p ^ cc[3:0];
            c = cc[4];
        end
        cout = c;
    end

endmodule

// File: rtl/stream_accumulator.sv
// Sums a burst of LEN unsigned operands from a valid/ready stream through a registered
// cla feedback loop; returns the total and a sticky carry-out flag on a valid/ready port.
module stream_accumulator
    import stream_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    acc_state_t       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             ovf_q;
    logic             cout_d;
    logic [CNT_W-1:0] rem_q;

    cla #(.width(WIDTH)) u_cla (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .s    (acc_d),
        .cout (cout_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        rem_q   <= len;
                        state_q <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    // in_ready is exactly "state is ACCUM", so in_valid alone marks a beat.
                    if (in_valid) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_q | cout_d;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// Randomized self-checking bench for stream_accumulator against a 64-bit arithmetic model.
module tb_stream_accumulator;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    stream_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model: exact sum in 64 bits; result is the low word, overflow is "exceeded a word".
    function automatic logic [WIDTH-1:0] model_sum(input logic [63:0] total);
        return total[WIDTH-1:0];
    endfunction

    function automatic logic model_ovf(input logic [63:0] total);
        return total >= 64'h1_0000_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    // Presents one operand after `gaps` idle cycles and holds it until accepted.
    task automatic send(input logic [WIDTH-1:0] d, input int gaps);
        bit taken = 0;
        in_valid = 1'b0;
        repeat (gaps) tick();
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        if (!taken) begin
            checks++; errors++;
            $display("FAIL send_timeout operand %h never accepted", d);
        end
    endtask

    task automatic wait_out(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, out_valid, in_ready, out_ovf} !== 4'b0 || out_sum !== '0) begin
            errors++;
            $display("FAIL reset_vals busy=%b ov=%b ir=%b ovf=%b sum=%h required all 0",
                     busy, out_valid, in_ready, out_ovf, out_sum);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        do_start(3);
        send(32'd5, 0);
        send(32'd7, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early out_valid=%b required 0", out_valid);
        end
        send(32'd9, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd21 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result ov=%b sum=%0d ovf=%b required 1 21 0",
                     out_valid, out_sum, out_ovf);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle busy=%b ov=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        out_ready = 1'b0;
        do_start(2);
        send(32'hFFFF_FFFF, 0);
        send(32'h2, 0);
        wait_out(ok);
        checks++;
        if (!ok || out_sum !== 32'h1 || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap ok=%b sum=%h ovf=%b required 1 00000001 1", ok, out_sum, out_ovf);
        end
        out_ready = 1'b1;
        tick();
        do_start(1);
        send(32'd4, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd4 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared ov=%b sum=%0d ovf=%b required 1 4 0", out_valid, out_sum, out_ovf);
        end
        tick();
    endtask

    task automatic test_zero_len();
        bit seen_ready = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        start = 1'b1;
        len   = '0;
        @(negedge clk); seen_ready |= in_ready;
        tick();
        start = 1'b0;
        @(negedge clk); seen_ready |= in_ready;
        #4;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== '0 || out_ovf !== 1'b0 || seen_ready) begin
            errors++;
            $display("FAIL zero_len ov=%b sum=%h ovf=%b in_ready_seen=%b required 1 0 0 0",
                     out_valid, out_sum, out_ovf, seen_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_gaps_backpressure();
        bit ok;
        logic [63:0] total = 0;
        logic [WIDTH-1:0] d;
        out_ready = 1'b0;
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            total += 64'(d);
            send(d, int'($urandom_range(0, 3)));
        end
        wait_out(ok);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (!ok || out_valid !== 1'b1 || out_sum !== model_sum(total) || out_ovf !== model_ovf(total)) begin
                errors++;
                $display("FAIL hold_cycle%0d ov=%b sum=%h ovf=%b required 1 %h %b",
                         k, out_valid, out_sum, out_ovf, model_sum(total), model_ovf(total));
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_start_ignored();
        out_ready = 1'b0;
        do_start(3);
        send(32'd100, 0);
        start = 1'b1;
        len   = 8'd7;
        tick();
        start = 1'b0;
        send(32'd20, 0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL start_accum ov=%b busy=%b required 0 1", out_valid, busy);
        end
        send(32'd3, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd123) begin
            errors++; $display("FAIL start_accum_sum ov=%b sum=%0d required 1 123", out_valid, out_sum);
        end
        start = 1'b1;
        len   = 8'd2;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd123) begin
            errors++; $display("FAIL start_done ov=%b sum=%0d required 1 123", out_valid, out_sum);
        end
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL start_at_accept busy=%b ov=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_midburst();
        out_ready = 1'b1;
        do_start(4);
        send(32'd50, 0);
        send(32'd60, 0);
        #3;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, out_valid, in_ready, out_ovf} !== 4'b0 || out_sum !== '0) begin
            errors++;
            $display("FAIL midburst_reset busy=%b ov=%b ir=%b ovf=%b sum=%h required all 0",
                     busy, out_valid, in_ready, out_ovf, out_sum);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_start(1);
        send(32'd10, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd10 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL after_reset ov=%b sum=%0d ovf=%b required 1 10 0", out_valid, out_sum, out_ovf);
        end
        tick();
    endtask

    task automatic test_random();
        bit ok;
        int n;
        logic [63:0] total;
        logic [WIDTH-1:0] d;
        for (int b = 0; b < 10; b++) begin
            n = int'($urandom_range(1, 9));
            total = 0;
            out_ready = 1'b0;
            do_start(n);
            for (int i = 0; i < n; i++) begin
                d = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 1000));
                total += 64'(d);
                send(d, int'($urandom_range(0, 2)));
            end
            wait_out(ok);
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (!ok || out_valid !== 1'b1 || out_sum !== model_sum(total) || out_ovf !== model_ovf(total)) begin
                errors++;
                $display("FAIL random_burst%0d len=%0d ov=%b sum=%h ovf=%b required 1 %h %b",
                         b, n, out_valid, out_sum, out_ovf, model_sum(total), model_ovf(total));
            end
            out_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_len();
        test_gaps_backpressure();
        test_start_ignored();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
